// File: rtl/pipe_hazard_ctrl.sv
// Stall/forward controller: shifts per-instruction write records with
// self-decrementing Tnew through NSTAGE post-decode stages, plus a mult/div busy counter.
module pipe_hazard_ctrl #(
    parameter int  NSTAGE  = 3,
    parameter int  AW      = 5,
    parameter int  TW      = 2,
    parameter int  MUL_CYC = 5,
    parameter int  DIV_CYC = 10,
    localparam int FW      = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [FW-1:0] fwd_d_rs,
    output logic [FW-1:0] fwd_d_rt,
    output logic [FW-1:0] fwd_e_rs,
    output logic [FW-1:0] fwd_e_rt,
    output logic [FW-1:0] fwd_m_rt,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);
    localparam int            CW        = $clog2(DIV_CYC + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] a3;
        logic [TW-1:0] tnew;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [TW-1:0] tuse_rs;
        logic [TW-1:0] tuse_rt;
    } rec_t;

    rec_t          rec [1:NSTAGE];
    rec_t          d_rec;
    logic [CW-1:0] md_cnt;
    logic          op_stall;
    logic          md_stall;

    function automatic rec_t age(input rec_t r);
        rec_t o;
        o = r;
        if (r.tnew != '0) o.tnew = r.tnew - 1'b1;
        return o;
    endfunction

    // Youngest matching writer beyond consumer stage k (sel = 0 when none);
    // scanning oldest-to-youngest lets the youngest overwrite the result.
    function automatic void find(input logic [AW-1:0] x, input int unsigned k,
                                 output logic [FW-1:0] sel, output logic [TW-1:0] tn);
        sel = '0;
        tn  = '0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            if ((NSTAGE - i) > k && rec[NSTAGE-i].valid &&
                rec[NSTAGE-i].a3 == x && x != '0) begin
                sel = FW'(NSTAGE - i);
                tn  = rec[NSTAGE-i].tnew;
            end
        end
    endfunction

    function automatic logic [FW-1:0] fwd(input logic [AW-1:0] x, input logic [TW-1:0] tuse,
                                          input int unsigned k);
        logic [FW-1:0] sel;
        logic [TW-1:0] tn;
        find(x, k, sel, tn);
        return (tuse != TUSE_NONE && tn == '0) ? sel : '0;
    endfunction

    function automatic logic hazard(input logic [AW-1:0] x, input logic [TW-1:0] tuse);
        logic [FW-1:0] sel;
        logic [TW-1:0] tn;
        find(x, 0, sel, tn);
        return (tuse != TUSE_NONE) && (sel != '0) && (tn > tuse);
    endfunction

    assign md_busy = (md_cnt != '0);

    always_comb begin
        d_rec = '{valid: d_valid, a3: d_a3, tnew: d_tnew, rs: d_rs, rt: d_rt,
                  tuse_rs: d_tuse_rs, tuse_rt: d_tuse_rt};
        op_stall = hazard(d_rs, d_tuse_rs) | hazard(d_rt, d_tuse_rt);
        md_stall = md_busy & (d_md_start | d_md_use);
        stall    = op_stall | md_stall;
        fwd_d_rs = fwd(d_rs, d_tuse_rs, 0);
        fwd_d_rt = fwd(d_rt, d_tuse_rt, 0);
        fwd_e_rs = fwd(rec[1].rs, rec[1].tuse_rs, 1);
        fwd_e_rt = fwd(rec[1].rt, rec[1].tuse_rt, 1);
        fwd_m_rt = fwd(rec[2].rt, rec[2].tuse_rt, 2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 1; s <= NSTAGE; s++) rec[s] <= '0;
            md_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) rec[1] <= '0;
            else       rec[1] <= d_rec;
            for (int unsigned s = 2; s <= NSTAGE; s++) rec[s] <= age(rec[s-1]);

            if (d_valid && !stall && d_md_start)
                md_cnt <= d_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
            else if (md_busy)
                md_cnt <= md_cnt - 1'b1;

            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised stall/forward controller for the in-order pipeline. It tracks a shift pipeline of per-instruction write records with self-decrementing Tnew across NSTAGE post-decode stages. It produces the D-stage stall and the forwarding selects for D, E and M consumers, and adds a multiply/divide busy counter and a stall-cycle counter. It sits beside the datapath, consuming the decoder's Tuse/Tnew/address fields for the instruction in D.

## Interface
- NSTAGE, 3: post-decode stages tracked (stage 1 = E … stage NSTAGE = W); legal range 3..7
- AW, 5: register address width
- TW, 2: Tnew/Tuse width; Tuse all-ones means operand unused
- MUL_CYC, 5: multiply busy cycles
- DIV_CYC, 10: divide busy cycles
- FW: derived as clog2(NSTAGE+1), forwarding select width
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- d_valid  input  1  D holds a real instruction
- d_rs, d_rt  input  AW  source addresses of the D instruction
- d_tuse_rs, d_tuse_rt  input  TW  cycles until each source is needed (all-ones = unused)
- d_a3  input  AW  destination address (0 = no write)
- d_tnew  input  TW  cycles from E entry until the result exists
- d_md_start  input  1  D is mult/div
- d_md_div  input  1  qualifies d_md_start: 1 = divide
- d_md_use  input  1  D reads or writes HI/LO (mfhi/mflo/mthi/mtlo)
- stall  output  1  hold F/D, bubble into E
- fwd_d_rs, fwd_d_rt  output  FW  D-operand source: 0 = GRF, s = stage-s result
- fwd_e_rs, fwd_e_rt  output  FW  E-operand source, s ≥ 2 or 0
- fwd_m_rt  output  FW  M store-data source, s ≥ 3 or 0
- md_busy  output  1  mult/div counter nonzero
- stall_cnt  output  32  total stall cycles, saturating

## Operation
- Record per stage: valid, a3, tnew, rs, rt, tuse_rs, tuse_rt.
- Each edge, record s moves to s+1, and tnew becomes max(tnew−1, 0). The record at NSTAGE drops.
- Stage 1 loads the D fields with valid = d_valid & ~stall. When stall = 1 it loads a bubble (valid = 0, a3 = 0).
- A match for address x at stage s requires: valid, a3 == x, and x != 0.
- Stall rule per D operand with tuse != all-ones:
  - Find the youngest (smallest s) matching stage.
  - Stall if its tnew > tuse.
  - Older matches are ignored.
- Forward select for a consumer of stage k (k = 0 for D, 1 for E, 2 for M):
  - Consider the youngest matching stage s > k.
  - If its tnew == 0, output s; otherwise output 0.
  - An unused operand or address 0 gives 0.
- E and M consumers use their own stage's stored rs/rt.
- Mult/div counter (width clog2(DIV_CYC+1)):
  - Loads MUL_CYC, or DIV_CYC when d_md_div = 1, on the edge where d_md_start issues (d_valid & ~stall).
  - Otherwise decrements to 0.
  - md_busy = (counter != 0).
- stall = operand-stall | (md_busy & (d_md_start | d_md_use)).
- stall_cnt increments on every edge with stall = 1 and saturates at 0xFFFF_FFFF.

## Timing
- stall, all fwd_* and md_busy are combinational from the record registers, the counter and the D inputs. There is no extra latency.
- Record shift, counter and stall_cnt update on the rising edge of clk.
- While reset = 0:
  - all records are invalid, the counter is 0 and stall_cnt is 0;
  - hence stall = 0, all fwd_* = 0, md_busy = 0.
- Reset asserted mid-operation discards all in-flight records immediately, with no wait for the clock.
- Simultaneous events:
  - An md op issuing while md_busy = 1 is impossible, because it stalls.
  - Stall and forward may both be asserted; D consumers honour stall, and E/M forwards remain valid.
- With multiple writers to the same register, the youngest always wins, including one with tnew > 0. In that case fwd = 0 and an operand stall results if tuse is violated.

## Test plan
- Reset:
  - Stimulus: pulse reset = 0 asynchronously while three valid writers are in flight.
  - Response: within the same cycle, stall = 0 and all fwd_* = 0. After release, stall_cnt = 0.
- Load-use:
  - Stimulus: lw (a3 = 8, tnew = 2), then add (rs = 8, tuse_rs = 1).
  - Response: stall = 1 for exactly one cycle. The next cycle has stall = 0 and fwd_d_rs = 0. When add is in E, fwd_e_rs = 3.
- ALU-to-branch:
  - Stimulus: addu (a3 = 9, tnew = 1), then beq (rs = 9, tuse = 0).
  - Response: one stall cycle, then fwd_d_rs = 2 with stall = 0.
- $0 and priority:
  - Stimulus: a writer with a3 = 0 followed by a reader of $0.
  - Response: no stall and fwd = 0.
  - Stimulus: two back-to-back writers of $4 with tnew = 0.
  - Response: a D reader gets fwd_d_rs = 1.
- Mult/div:
  - Stimulus: mult, then mflo immediately.
  - Response: stall = 1 for 5 cycles; mflo issues on the 6th cycle.
  - Stimulus: div, then div.
  - Response: 10 stall cycles.
  - Response in both cases: stall_cnt grows by exactly the stall count.
- Saturation:
  - Stimulus: force stall_cnt to 0xFFFF_FFFE and hold a stall for 3 cycles.
  - Response: stall_cnt reads 0xFFFF_FFFF.
